// File: rtl/tpu_pkg.sv
// Shared TPU definitions: default operand/array sizes, skew feeder FSM states
// and the lane packing helper used wherever a row vector is sliced per lane.
package tpu_pkg;

  localparam int unsigned DefBitsAb = 8;
  localparam int unsigned DefDim    = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } skew_state_t;

  // Lane i of a packed row vector starts at bit i*bits.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned bits);
    return lane * bits;
  endfunction

endpackage

// File: rtl/tpu_skew_lane.sv
// DEPTH-stage, BITS_AB-wide shift register; all stages move together on shift_en_i.
module tpu_skew_lane #(
  parameter int unsigned DEPTH   = 1,
  parameter int unsigned BITS_AB = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               shift_en_i,
  input  logic [BITS_AB-1:0] din_i,
  output logic [BITS_AB-1:0] dout_o
);

  logic [DEPTH-1:0][BITS_AB-1:0] stage_q, stage_d;

  always_comb begin
    stage_d = stage_q;
    if (shift_en_i) begin
      stage_d[0] = din_i;
      for (int unsigned s = 1; s < DEPTH; s++) begin
        stage_d[s] = stage_q[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/tpu_skew_feeder.sv
// Skews a DIM-lane operand row into a diagonal wavefront for the systolic array,
// gating the array enable so array and feeder only advance together.
module tpu_skew_feeder
  import tpu_pkg::*;
#(
  parameter int unsigned BITS_AB = DefBitsAb,
  parameter int unsigned DIM     = DefDim
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DIM*BITS_AB-1:0] in_vec,
  input  logic                   in_last,
  output logic [DIM*BITS_AB-1:0] out_vec,
  output logic                   out_en,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned CntW = 5;
  localparam logic [CntW-1:0] FlushInit = CntW'((DIM > 1) ? DIM - 2 : 0);

  skew_state_t     state_q, state_d;
  logic [CntW-1:0] flush_cnt_q, flush_cnt_d;
  logic            out_en_q, out_en_d;
  logic            done_q, done_d;
  logic            accept, advance;

  assign accept  = in_valid && in_ready;
  assign advance = accept || (state_q == FLUSH);

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    in_ready    = 1'b0;
    unique case (state_q)
      IDLE, STREAM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_last) begin
            state_d     = (DIM == 1) ? DONE : FLUSH;
            flush_cnt_d = FlushInit;
          end else begin
            state_d = STREAM;
          end
        end
      end
      FLUSH: begin
        if (flush_cnt_q == '0) begin
          state_d = DONE;
        end else begin
          flush_cnt_d = flush_cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // done lands with the out_en of the final advance of the tile.
  always_comb begin
    out_en_d = advance;
    done_d   = ((state_q == FLUSH) && (flush_cnt_q == '0)) ||
               ((DIM == 1) && accept && in_last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
      out_en_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      out_en_q    <= out_en_d;
      done_q      <= done_d;
    end
  end

  for (genvar i = 0; i < DIM; i++) begin : g_lane
    logic [BITS_AB-1:0] lane_in, lane_out;

    // Zeros are shifted in while flushing the wavefront.
    assign lane_in = accept ? in_vec[lane_lsb(i, BITS_AB) +: BITS_AB] : '0;

    tpu_skew_lane #(
      .DEPTH  (i + 1),
      .BITS_AB(BITS_AB)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .shift_en_i(advance),
      .din_i     (lane_in),
      .dout_o    (lane_out)
    );

    assign out_vec[lane_lsb(i, BITS_AB) +: BITS_AB] = out_en_q ? lane_out : '0;
  end

  assign out_en = out_en_q;
  assign done   = done_q;
  assign busy   = (state_q != IDLE);

endmodule
